// File: rtl/tappy_pkg.sv
// Shared PS/2 definitions: transmitter states, frame bit count and the
// odd-parity helper used by both the transmitter and the receiver.
package tappy_pkg;

    localparam int unsigned PS2_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        PRTY,
        STOP,
        ACK
    } tx_state_e;

    function automatic logic odd_parity(input logic [PS2_BITS-1:0] w);
        return ~^w;
    endfunction

endpackage

// File: rtl/tappy_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads, plus a one-cycle
// strobe marking a synchronized falling edge of the PS/2 clock.
module tappy_sync (
    input  logic sysclk,
    input  logic rst_n,
    input  logic clk_i,
    input  logic dat_i,
    output logic clk_o,
    output logic dat_o,
    output logic fall_c
);

    logic [1:0] clk_q;
    logic [1:0] dat_q;
    logic       clk_prev_q;

    // Reset to the idle (released, high) line level so no false edge appears.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            clk_q      <= 2'b11;
            dat_q      <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_q      <= {clk_q[0], clk_i};
            dat_q      <= {dat_q[0], dat_i};
            clk_prev_q <= clk_q[1];
        end
    end

    assign clk_o  = clk_q[1];
    assign dat_o  = dat_q[1];
    assign fall_c = clk_prev_q & ~clk_q[1];

endmodule

// File: rtl/tappy_send.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, LSB-first data
// with odd parity, stop-bit release and device acknowledge check.
module tappy_send
    import tappy_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic                clk,
    input  logic                dat,
    input  logic [PS2_BITS-1:0] word,
    input  logic                send,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                clk_oe,
    output logic                dat_oe
);

    localparam int unsigned TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                      INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned CNT_W   = $clog2(PS2_BITS + 1);

    logic clk_s;
    logic dat_s;
    logic fall_c;

    tappy_sync u_sync (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .clk_i  (clk),
        .dat_i  (dat),
        .clk_o  (clk_s),
        .dat_o  (dat_s),
        .fall_c (fall_c)
    );

    tx_state_e           state_q,  state_d;
    logic [PS2_BITS-1:0] word_q,   word_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [TMR_W-1:0]    tmr_q,    tmr_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                error_q,  error_d;
    logic                clk_oe_q, clk_oe_d;
    logic                dat_oe_q, dat_oe_d;
    logic                timeout_c;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            word_q   <= '0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        timeout_c = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

        unique case (state_q)
            IDLE: begin
                if (send) begin
                    word_d   = word;
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    dat_oe_d = 1'b0;
                    tmr_d    = '0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                // Releasing clock and pulling data in one step forms the start bit.
                if (tmr_q == TMR_W'(INHIBIT_CYCLES - 1)) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    tmr_d    = '0;
                    state_d  = RTS;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            RTS: begin
                if (fall_c) begin
                    dat_oe_d = ~word_q[0];
                    cnt_d    = CNT_W'(1);
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (fall_c) begin
                    if (cnt_q == CNT_W'(PS2_BITS)) begin
                        dat_oe_d = ~odd_parity(word_q);
                        state_d  = PRTY;
                    end else begin
                        dat_oe_d = ~word_q[cnt_q[CNT_W-2:0]];
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end
            end
            PRTY: begin
                if (fall_c) begin
                    dat_oe_d = 1'b0;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall_c) begin
                    if (!dat_s) begin
                        state_d = ACK;
                    end else begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            ACK: begin
                if (clk_s && dat_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Transfer watchdog; a completion in the same cycle takes priority.
        if (state_q inside {RTS, DATA, PRTY, STOP, ACK}) begin
            tmr_d = tmr_q + TMR_W'(1);
            if (timeout_c && !done_d && !error_d) begin
                error_d  = 1'b1;
                busy_d   = 1'b0;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;
    assign clk_oe = clk_oe_q;
    assign dat_oe = dat_oe_q;

endmodule

// File: tb/tb_tappy_send.sv
// Bench for tappy_send: open-drain PS/2 device model clocking at 40 sysclk
// per period, with a frame model derived from the PS/2 framing rules.
`timescale 1ns/1ps
module tb_tappy_send;

    localparam int unsigned INH  = 20;
    localparam int unsigned TO   = 2000;
    localparam int          HALF = 20;

    logic       sysclk  = 1'b0;
    logic       rst_n   = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic [7:0] word    = 8'h00;
    logic       send    = 1'b0;
    logic       busy, done, error, clk_oe, dat_oe;
    wire        ps2_clk, ps2_dat;

    assign ps2_clk = dev_clk & ~clk_oe;
    assign ps2_dat = dev_dat & ~dat_oe;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    logic [9:0] got;
    logic       oe9;

    tappy_send #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .clk    (ps2_clk),
        .dat    (ps2_dat),
        .word   (word),
        .send   (send),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .clk_oe (clk_oe),
        .dat_oe (dat_oe)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (done === 1'b1 && error === 1'b1) both_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Expected line levels: 8 data bits LSB first, odd parity, stop = 1.
    function automatic logic [9:0] ref_frame(input logic [7:0] w);
        int ones = $countones(w);
        logic [9:0] f;
        f[7:0] = w;
        f[8]   = ((ones % 2) == 0);
        f[9]   = 1'b1;
        return f;
    endfunction

    task automatic start_send(input logic [7:0] w);
        int n  = 1;
        int hi = 0;
        word = w;
        send = 1'b1;
        tick(1);
        send = 1'b0;
        word = 8'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_busy: busy=%b expected 1", busy);
        end
        while (dat_oe !== 1'b1 && n < int'(INH) + 50) begin
            if (clk_oe === 1'b1) hi++;
            tick(1);
            n++;
        end
        checks++;
        if (n != int'(INH) + 1) begin
            errors++;
            $display("FAIL rts_latency: got %0d cycles expected %0d", n, INH + 1);
        end
        checks++;
        if (hi != int'(INH) || clk_oe !== 1'b0) begin
            errors++;
            $display("FAIL inhibit_len: clk_oe high %0d cycles (expected %0d), clk_oe at rts=%b", hi, INH, clk_oe);
        end
    endtask

    task automatic device(input int nfalls, input bit ack);
        got = '0;
        oe9 = 1'bx;
        tick(10);
        for (int k = 1; k <= nfalls; k++) begin
            dev_clk = 1'b0;
            tick(HALF / 2);
            if (k <= 10) got[k-1] = ps2_dat;
            if (k == 9) oe9 = dat_oe;
            tick(HALF / 2);
            dev_clk = 1'b1;
            if (k == 10 && ack) dev_dat = 1'b0;
            if (k == 11) begin
                tick(5);
                dev_dat = 1'b1;
            end else begin
                tick(HALF);
            end
        end
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
    endtask

    task automatic check_done(input logic [7:0] w, input string tag);
        int n;
        checks++;
        if (got !== ref_frame(w)) begin
            errors++;
            $display("FAIL %s_frame: word=%h got %b expected %b", tag, w, got, ref_frame(w));
        end
        wait_end(n);
        checks++;
        if ({done, error, busy} !== 3'b100) begin
            errors++;
            $display("FAIL %s_done: done=%b error=%b busy=%b expected 1 0 0", tag, done, error, busy);
        end
        tick(1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: done=%b one cycle later expected 0", tag, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++;
        if ({busy, done, error, clk_oe, dat_oe} !== 5'b0) begin
            errors++;
            $display("FAIL reset: busy/done/error/clk_oe/dat_oe=%b expected 00000",
                     {busy, done, error, clk_oe, dat_oe});
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_ed();
        start_send(8'hED);
        device(11, 1'b1);
        checks++;
        if (got[7:0] !== 8'b1110_1101 || got[8] !== 1'b1) begin
            errors++;
            $display("FAIL ed_bits: data=%b parity=%b expected 11101101 1", got[7:0], got[8]);
        end
        check_done(8'hED, "ed");
    endtask

    task automatic test_parity_zero();
        start_send(8'h01);
        device(11, 1'b1);
        checks++;
        if (oe9 !== 1'b1) begin
            errors++;
            $display("FAIL parity0_oe: dat_oe after fall 9 = %b expected 1", oe9);
        end
        check_done(8'h01, "par0");
    endtask

    task automatic test_timeout();
        int n = 0;
        int d0 = done_cnt;
        start_send(8'($urandom));
        while (error !== 1'b1 && n < int'(TO) + 100) begin
            tick(1);
            n++;
        end
        checks++;
        if (n != int'(TO)) begin
            errors++;
            $display("FAIL timeout_cycles: error after %0d cycles expected %0d", n, TO);
        end
        checks++;
        if ({clk_oe, dat_oe, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL timeout_lines: clk_oe/dat_oe/busy/done=%b expected 0000",
                     {clk_oe, dat_oe, busy, done});
        end
        tick(1);
        checks++;
        if (error !== 1'b0 || done_cnt != d0) begin
            errors++;
            $display("FAIL timeout_pulse: error=%b done pulses=%0d expected 0 0", error, done_cnt - d0);
        end
    endtask

    task automatic test_no_ack();
        logic [7:0] w = 8'($urandom);
        int d0 = done_cnt;
        int e0 = err_cnt;
        start_send(w);
        device(11, 1'b0);
        tick(5);
        checks++;
        if (got !== ref_frame(w)) begin
            errors++;
            $display("FAIL noack_frame: got %b expected %b", got, ref_frame(w));
        end
        checks++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL noack: error pulses=%0d done pulses=%0d busy=%b expected 1 0 0",
                     err_cnt - e0, done_cnt - d0, busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] w = 8'($urandom);
            start_send(w);
            device(11, 1'b1);
            check_done(w, "b2b");
        end
    endtask

    task automatic test_busy_reset();
        start_send(8'h00);
        device(3, 1'b1);
        word = 8'hFF;
        send = 1'b1;
        tick(1);
        send = 1'b0;
        checks++;
        if (busy !== 1'b1 || dat_oe !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignore: busy=%b dat_oe=%b expected 1 1", busy, dat_oe);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({clk_oe, dat_oe, busy} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: clk_oe/dat_oe/busy=%b expected 000", {clk_oe, dat_oe, busy});
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        start_send(8'hFF);
        device(11, 1'b1);
        check_done(8'hFF, "after_rst");
    endtask

    initial begin
        test_reset();
        test_ed();
        test_parity_zero();
        test_timeout();
        test_no_ack();
        test_back_to_back();
        test_busy_reset();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL done_and_error: %0d cycles with both high expected 0", both_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
